ysyx_24100005_lsu: RTL

Load/store unit sitting directly downstream of the core datapath's address adder and register file. It accepts one load or store request per transaction and drives a simplified AXI4-Lite memory port with independent AR/R/AW/W/B channels. For loads it returns byte/half/word data, sign- or zero-extended; for stores it generates the write strobes. This unit replaces the combinational DPI memory access and makes memory latency variable.

---
 rtl/ysyx_24100005_lsu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: turns one core load/store request into AXI4-Lite-style
// read or write transactions, handling lane selection, extension and strobes.
module ysyx_24100005_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,

  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,

  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp
);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StResp} state_e;

  state_e              state_q, state_d;
  logic                wen_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                aw_done_q, w_done_q;

  logic                legal_f3, misalign, req_bad;
  logic                aw_fire, w_fire;
  logic [ADDR_W-1:0]   addr_aligned;
  logic [DATA_W-1:0]   rd_shift, ld_data, wr_lanes;
  logic [15:0]         rd_half;
  logic [3:0]          wr_strb;

  // Request decode: legality and natural alignment of the incoming access.
  always_comb begin
    if (req_wen) begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_bad  = !legal_f3 || misalign;
  end

  assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};
  assign aw_fire      = mem_awvalid && mem_awready;
  assign w_fire       = mem_wvalid && mem_wready;

  // Load lane extraction and sign/zero extension.
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'h0, rd_shift[7:0]};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Store lane replication and byte strobes.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wr_strb  = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_strb  = 4'b0011 << addr_q[1:0];
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_strb  = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_bad)      state_d = StResp;
          else if (req_wen) state_d = StWrReq;
          else              state_d = StRdAddr;
        end
      end
      StRdAddr: if (mem_arready) state_d = StRdData;
      StRdData: if (mem_rvalid)  state_d = StResp;
      StWrReq:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = StWrResp;
      StWrResp: if (mem_bvalid)  state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs depend only on state and registered data, never on memory readies.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_rready  = 1'b0;
    mem_awvalid = 1'b0;
    mem_awaddr  = '0;
    mem_wvalid  = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = 4'b0000;
    mem_bready  = 1'b0;
    unique case (state_q)
      StIdle:   req_ready = 1'b1;
      StRdAddr: begin
        mem_arvalid = 1'b1;
        mem_araddr  = addr_aligned;
      end
      StRdData: mem_rready = 1'b1;
      StWrReq: begin
        mem_awvalid = !aw_done_q;
        mem_awaddr  = addr_aligned;
        mem_wvalid  = !w_done_q;
        mem_wdata   = wr_lanes;
        mem_wstrb   = wr_strb;
      end
      StWrResp: mem_bready = 1'b1;
      StResp: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Request capture and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q     <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && req_valid) begin
        wen_q     <= req_wen;
        funct3_q  <= req_funct3;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        rdata_q   <= '0;
        err_q     <= req_bad;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == StRdData && mem_rvalid) begin
        rdata_q <= (mem_rresp != 2'b00) ? '0 : ld_data;
        err_q   <= (mem_rresp != 2'b00);
      end
      if (state_q == StWrReq) begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (state_q == StWrResp && mem_bvalid) begin
        err_q <= (mem_bresp != 2'b00);
      end
    end
  end

  logic unused_wen;
  assign unused_wen = wen_q;

endmodule
